// File: rtl/frogger_key_pkg.sv
// frogger_key_pkg: HID/set-2 constants, FSM state types and the scan-to-HID map
package frogger_key_pkg;

    localparam logic [15:0] KEY_NONE  = 16'h0000;
    localparam logic [15:0] KEY_W     = 16'h001A;
    localparam logic [15:0] KEY_A     = 16'h0004;
    localparam logic [15:0] KEY_S     = 16'h0016;
    localparam logic [15:0] KEY_D     = 16'h0007;
    localparam logic [15:0] KEY_SPACE = 16'h002C;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
    typedef enum logic [1:0] {NORM, EXT, BRK, EXT_BRK} byte_state_t;

    // Returns {mapped, hid}; arrows alias onto W/A/S/D
    function automatic logic [16:0] hid_map(input logic ext, input logic [7:0] code);
        case ({ext, code})
            {1'b0, SC_W}, {1'b1, SC_UP}:    hid_map = {1'b1, KEY_W};
            {1'b0, SC_A}, {1'b1, SC_LEFT}:  hid_map = {1'b1, KEY_A};
            {1'b0, SC_S}, {1'b1, SC_DOWN}:  hid_map = {1'b1, KEY_S};
            {1'b0, SC_D}, {1'b1, SC_RIGHT}: hid_map = {1'b1, KEY_D};
            {1'b0, SC_SPACE}:               hid_map = {1'b1, KEY_SPACE};
            default:                        hid_map = {1'b0, KEY_NONE};
        endcase
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: conditions the PS/2 pins and deframes 11-bit frames into bytes
module ps2_frame_rx
    import frogger_key_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            clk_s, dat_s;
    logic [FILTER_LEN-1:0] sh;
    logic                  lvl, fall, timeout, par_ok;
    logic [CW-1:0]         cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            sr;
    frame_state_t          st;

    assign fall      = lvl && (sh == '0);
    assign timeout   = (st != IDLE) && (cnt == CW'(TIMEOUT_CYCLES));
    assign byte_data = sr;

    // Two-flop synchronisers, then a shift filter that only accepts unanimous levels
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            clk_s <= 2'b11;
            dat_s <= 2'b11;
            sh    <= '1;
            lvl   <= 1'b1;
        end else begin
            clk_s <= {clk_s[0], ps2_clk};
            dat_s <= {dat_s[0], ps2_data};
            sh    <= {sh[FILTER_LEN-2:0], clk_s[1]};
            lvl   <= (&sh) ? 1'b1 : (~|sh) ? 1'b0 : lvl;
        end

    // Timeout counter: runs only mid-frame, cleared by every falling edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (fall || timeout || st == IDLE) ? '0 : cnt + 1'b1;

    // Frame FSM; a timeout pre-empts any edge sampled in the same cycle
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st         <= IDLE;
            bit_cnt    <= '0;
            sr         <= '0;
            par_ok     <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (timeout) begin
                frame_err <= 1'b1;
                st        <= IDLE;
            end else if (fall) begin
                case (st)
                    IDLE: if (!dat_s[1]) begin
                        st      <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        sr      <= {dat_s[1], sr[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) st <= PARITY;
                    end
                    PARITY: begin
                        par_ok <= ^{sr, dat_s[1]};
                        st     <= STOP;
                    end
                    STOP: begin
                        st <= IDLE;
                        if (dat_s[1] && par_ok) byte_valid <= 1'b1;
                        else frame_err <= 1'b1;
                    end
                endcase
            end
        end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder: turns PS/2 set-2 make/break sequences into a held HID keycode
module ps2_keycode_decoder
    import frogger_key_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        key_event,
    output logic        frame_err,
    output logic [7:0]  last_byte
);

    logic        byte_valid, is_ext, is_brk, is_pfx, do_make, do_clr;
    logic [7:0]  byte_data;
    logic [16:0] m;
    logic [15:0] key_next;
    byte_state_t bst, bst_next;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign is_ext  = (bst == EXT) || (bst == EXT_BRK);
    assign is_brk  = (bst == BRK) || (bst == EXT_BRK);
    assign is_pfx  = (byte_data == SC_E0) || (byte_data == SC_F0);
    assign m       = hid_map(is_ext, byte_data);
    assign do_make = !is_brk && !is_pfx && m[16];
    assign do_clr  = is_brk && m[16] && (m[15:0] == keycode);

    // Next keycode and prefix state for the byte being delivered
    always_comb begin
        key_next = do_make ? m[15:0] : do_clr ? KEY_NONE : keycode;
        bst_next = (bst == NORM || bst == EXT)
                 ? ((byte_data == SC_F0) ? ((bst == EXT) ? EXT_BRK : BRK)
                    : (byte_data == SC_E0) ? EXT : NORM)
                 : NORM;
    end

    // Byte FSM and held keycode; key_event only when the value actually changes
    always_ff @(posedge Clk or negedge Reset_n)
        if (!Reset_n) begin
            bst       <= NORM;
            keycode   <= KEY_NONE;
            key_event <= 1'b0;
            last_byte <= '0;
        end else begin
            key_event <= 1'b0;
            if (byte_valid) begin
                bst       <= bst_next;
                last_byte <= byte_data;
                keycode   <= key_next;
                key_event <= (key_next != keycode);
            end
        end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// tb_ps2_keycode_decoder: directed PS/2 frame sequences with hand-computed expectations
module tb_ps2_keycode_decoder;

    logic        clk = 1'b0;
    logic        Reset_n, ps2_clk, ps2_data;
    logic [15:0] keycode;
    logic        key_event, frame_err;
    logic [7:0]  last_byte;
    int          n_chk = 0, n_fail = 0, ev = 0, er = 0;

    ps2_keycode_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(300)) dut (
        .Clk      (clk),
        .Reset_n  (Reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keycode  (keycode),
        .key_event(key_event),
        .frame_err(frame_err),
        .last_byte(last_byte)
    );

    always #5 clk = ~clk;

    // Pulse counters; a pulse held longer than one cycle inflates the count
    always @(negedge clk)
        if (Reset_n) begin
            if (key_event) ev++;
            if (frame_err) er++;
        end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (10) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(posedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] code, input logic pflip = 1'b0, input logic sb = 1'b1);
        send_bits({sb, (~^code) ^ pflip, code, 1'b0}, 11);
        repeat (30) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        Reset_n  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_keycode", keycode, 16'h0000);
        check("rst_key_event", key_event, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_last_byte", last_byte, 8'h00);
        Reset_n = 1'b1;
        repeat (5) @(posedge clk);

        frame(8'h29);
        check("pre_space", keycode, 16'h002C);
        check("pre_ev", ev, 1);
        send_bits({2'b11, ~^8'h1D, 8'h1D, 1'b0}, 5);
        Reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_keycode", keycode, 16'h0000);
        check("midrst_last_byte", last_byte, 8'h00);
        Reset_n = 1'b1;
        repeat (5) @(posedge clk);
        frame(8'h1D);
        check("t1_keycode", keycode, 16'h001A);
        check("t1_last_byte", last_byte, 8'h1D);
        check("t1_ev", ev, 2);
        frame(8'hF0);
        frame(8'h1D);
        check("t1_break", keycode, 16'h0000);
        check("t1_break_ev", ev, 3);

        frame(8'h1D);
        check("t2_make", keycode, 16'h001A);
        check("t2_make_ev", ev, 4);
        frame(8'hF0);
        frame(8'h1D);
        check("t2_break", keycode, 16'h0000);
        check("t2_break_ev", ev, 5);

        frame(8'hE0);
        check("t3_e0_last_byte", last_byte, 8'hE0);
        check("t3_e0_keycode", keycode, 16'h0000);
        frame(8'h75);
        check("t3_up", keycode, 16'h001A);
        check("t3_up_ev", ev, 6);
        for (int i = 0; i < 5; i++) frame(8'h1D);
        check("t3_typematic", keycode, 16'h001A);
        check("t3_typematic_ev", ev, 6);
        frame(8'hE0);
        frame(8'hF0);
        frame(8'h75);
        check("t3_ext_break", keycode, 16'h0000);
        check("t3_ext_break_ev", ev, 7);
        check("t3_last_byte", last_byte, 8'h75);

        frame(8'h1C);
        check("t4_a", keycode, 16'h0004);
        frame(8'h23);
        check("t4_d", keycode, 16'h0007);
        check("t4_ev", ev, 9);
        frame(8'hF0);
        frame(8'h1C);
        check("t4_old_break", keycode, 16'h0007);
        check("t4_old_break_ev", ev, 9);
        frame(8'hF0);
        frame(8'h23);
        check("t4_break", keycode, 16'h0000);
        check("t4_break_ev", ev, 10);

        frame(8'h1D, 1'b1);
        check("t5_par_err", er, 1);
        check("t5_par_keycode", keycode, 16'h0000);
        check("t5_par_last_byte", last_byte, 8'h23);
        frame(8'h1D, 1'b0, 1'b0);
        check("t5_stop_err", er, 2);
        check("t5_stop_keycode", keycode, 16'h0000);
        check("t5_stop_last_byte", last_byte, 8'h23);
        check("t5_ev", ev, 10);

        send_bits({2'b11, ~^8'h29, 8'h29, 1'b0}, 3);
        repeat (400) @(posedge clk);
        @(negedge clk);
        check("t6_timeout_err", er, 3);
        frame(8'h29);
        check("t6_space", keycode, 16'h002C);
        check("t6_space_ev", ev, 11);
        check("t6_space_err", er, 3);

        ps2_data = 1'b0;
        repeat (5) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
        ps2_data = 1'b1;
        repeat (400) @(posedge clk);
        frame(8'h1C);
        check("t6_glitch_keycode", keycode, 16'h0004);
        check("t6_glitch_err", er, 3);
        check("t6_glitch_ev", ev, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
